nms_filter: RTL and testbench

NMS_FILTER -- requirements
Module: nms_filter

---
 rtl/nms_pkg.sv | 15 +
 rtl/nms_iou_unit.sv | 66 ++++++
 rtl/nms_filter.sv | 177 +++++++++++++++++
 tb/tb_nms_filter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nms_pkg.sv
// Shared definitions for the NMS filter: FSM encoding and default widths.
package nms_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        EMIT    = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam int unsigned N_DEF    = 16;  // coordinate / IoU field width
    localparam int unsigned FRAC_DEF = 10;  // IoU fraction bits, 1.0 = 1 << FRAC
    localparam int unsigned EDGE_EXT = 1;   // box edges (x+w, y+h) carry one extra bit

endpackage

// File: rtl/nms_iou_unit.sv
// Combinational intersection-over-union of two boxes, fixed point with FRAC
// fraction bits, truncated and saturated to N bits; zero union gives zero.
module nms_iou_unit
    import nms_pkg::*;
#(
    parameter int unsigned N    = N_DEF,
    parameter int unsigned FRAC = FRAC_DEF
) (
    input  logic [N-1:0] a_x,
    input  logic [N-1:0] a_y,
    input  logic [N-1:0] a_w,
    input  logic [N-1:0] a_h,
    input  logic [N-1:0] b_x,
    input  logic [N-1:0] b_y,
    input  logic [N-1:0] b_w,
    input  logic [N-1:0] b_h,
    output logic [N-1:0] iou
);

    localparam int unsigned EW = N + EDGE_EXT;
    localparam int unsigned AW = 2 * N;
    localparam int unsigned UW = 2 * N + 1;
    localparam int unsigned DW = 2 * N + FRAC;

    logic [EW-1:0] ax0, ax1, ay0, ay1, bx0, bx1, by0, by1;
    logic [EW-1:0] lo_x, hi_x, lo_y, hi_y, iw, ih;
    logic [AW-1:0] inter, area_a, area_b;
    logic [UW-1:0] uni;
    logic [DW-1:0] num, quot;

    always_comb begin
        ax0 = {1'b0, a_x};
        ay0 = {1'b0, a_y};
        bx0 = {1'b0, b_x};
        by0 = {1'b0, b_y};
        ax1 = {1'b0, a_x} + {1'b0, a_w};
        ay1 = {1'b0, a_y} + {1'b0, a_h};
        bx1 = {1'b0, b_x} + {1'b0, b_w};
        by1 = {1'b0, b_y} + {1'b0, b_h};

        lo_x = (ax0 > bx0) ? ax0 : bx0;
        hi_x = (ax1 < bx1) ? ax1 : bx1;
        lo_y = (ay0 > by0) ? ay0 : by0;
        hi_y = (ay1 < by1) ? ay1 : by1;
        iw   = (hi_x > lo_x) ? (hi_x - lo_x) : '0;
        ih   = (hi_y > lo_y) ? (hi_y - lo_y) : '0;

        // Overlap never exceeds the smaller box, so the product fits in 2N bits.
        inter  = AW'(iw) * AW'(ih);
        area_a = AW'(a_w) * AW'(a_h);
        area_b = AW'(b_w) * AW'(b_h);
        uni    = UW'(area_a) + UW'(area_b) - UW'(inter);

        num  = DW'(inter) << FRAC;
        quot = (uni == '0) ? '0 : (num / DW'(uni));

        if (uni == '0) begin
            iou = '0;
        end else if (quot > DW'({N{1'b1}})) begin
            iou = '1;
        end else begin
            iou = quot[N-1:0];
        end
    end

endmodule

// File: rtl/nms_filter.sv
// Streaming non-maximum suppression: each candidate (score-sorted) is checked
// against the boxes kept so far this frame, one per cycle, and kept if no IoU exceeds the threshold.
module nms_filter
    import nms_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned FRAC  = FRAC_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N-1:0]                 in_x,
    input  logic [N-1:0]                 in_y,
    input  logic [N-1:0]                 in_w,
    input  logic [N-1:0]                 in_h,
    input  logic                         in_last,
    input  logic [N-1:0]                 iou_thresh,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N-1:0]                 out_x,
    output logic [N-1:0]                 out_y,
    output logic [N-1:0]                 out_w,
    output logic [N-1:0]                 out_h,
    output logic                         frame_done,
    output logic [$clog2(DEPTH+1)-1:0]   kept_count,
    output logic                         overflow
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [N-1:0]  cx_q, cy_q, cw_q, ch_q, thr_q;
    logic          last_q;
    logic          load, store, full;

    logic [N-1:0]  kx_q [DEPTH];
    logic [N-1:0]  ky_q [DEPTH];
    logic [N-1:0]  kw_q [DEPTH];
    logic [N-1:0]  kh_q [DEPTH];
    logic [N-1:0]  sx, sy, sw, sh, iou;

    always_comb begin
        sx = '0;
        sy = '0;
        sw = '0;
        sh = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (idx_q == CW'(i)) begin
                sx = kx_q[i];
                sy = ky_q[i];
                sw = kw_q[i];
                sh = kh_q[i];
            end
        end
    end

    nms_iou_unit #(
        .N    (N),
        .FRAC (FRAC)
    ) u_iou (
        .a_x (sx),
        .a_y (sy),
        .a_w (sw),
        .a_h (sh),
        .b_x (cx_q),
        .b_y (cy_q),
        .b_w (cw_q),
        .b_h (ch_q),
        .iou (iou)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        load       = 1'b0;
        store      = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        frame_done = 1'b0;
        full       = (count_q == CW'(DEPTH));

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = (count_q == '0) ? EMIT : COMPARE;
                end
            end
            COMPARE: begin
                if (iou > thr_q) begin
                    state_d = last_q ? DONE : IDLE;
                end else if ((idx_q + CW'(1)) == count_q) begin
                    state_d = EMIT;
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
            EMIT: begin
                if (full) begin
                    ovf_d   = 1'b1;
                    state_d = last_q ? DONE : IDLE;
                end else begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        store   = 1'b1;
                        count_d = count_q + CW'(1);
                        state_d = last_q ? DONE : IDLE;
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
                count_d    = '0;
                ovf_d      = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
            cw_q    <= '0;
            ch_q    <= '0;
            thr_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (load) begin
                cx_q   <= in_x;
                cy_q   <= in_y;
                cw_q   <= in_w;
                ch_q   <= in_h;
                thr_q  <= iou_thresh;
                last_q <= in_last;
            end
        end
    end

    // Box storage is deliberately unreset; only count_q decides which slots are live.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (store && (count_q == CW'(i))) begin
                kx_q[i] <= cx_q;
                ky_q[i] <= cy_q;
                kw_q[i] <= cw_q;
                kh_q[i] <= ch_q;
            end
        end
    end

    assign out_x      = cx_q;
    assign out_y      = cy_q;
    assign out_w      = cw_q;
    assign out_h      = ch_q;
    assign kept_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_nms_filter.sv
// Directed bench for nms_filter: DEPTH=8 and DEPTH=2 instances plus a standalone IoU unit.
module tb_nms_filter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid_a = 1'b0;
    logic        in_valid_b = 1'b0;
    logic [15:0] in_x = '0, in_y = '0, in_w = '0, in_h = '0;
    logic        in_last = 1'b0;
    logic [15:0] iou_thresh = 16'd512;
    logic        out_ready = 1'b1;

    logic        in_ready_a, out_valid_a, frame_done_a, overflow_a;
    logic [15:0] out_x_a, out_y_a, out_w_a, out_h_a;
    logic [3:0]  kept_count_a;
    logic        in_ready_b, out_valid_b, frame_done_b, overflow_b;
    logic [15:0] out_x_b, out_y_b, out_w_b, out_h_b;
    logic [1:0]  kept_count_b;

    logic [15:0] t_ax = '0, t_ay = '0, t_aw = '0, t_ah = '0;
    logic [15:0] t_bx = '0, t_by = '0, t_bw = '0, t_bh = '0;
    logic [15:0] t_iou;

    int n_cmp = 0;
    int n_err = 0;
    int hs_a = 0, hs_b = 0, fd_a = 0, fd_b = 0;
    logic [15:0] lx_a = '0, lw_a = '0;
    logic ov_fd_b = 1'b0;

    always #5 clk = ~clk;

    nms_filter #(.N(16), .DEPTH(8), .FRAC(10)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_x(in_x), .in_y(in_y), .in_w(in_w), .in_h(in_h), .in_last(in_last),
        .iou_thresh(iou_thresh),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_x(out_x_a), .out_y(out_y_a), .out_w(out_w_a), .out_h(out_h_a),
        .frame_done(frame_done_a), .kept_count(kept_count_a), .overflow(overflow_a)
    );

    nms_filter #(.N(16), .DEPTH(2), .FRAC(10)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_x(in_x), .in_y(in_y), .in_w(in_w), .in_h(in_h), .in_last(in_last),
        .iou_thresh(iou_thresh),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_x(out_x_b), .out_y(out_y_b), .out_w(out_w_b), .out_h(out_h_b),
        .frame_done(frame_done_b), .kept_count(kept_count_b), .overflow(overflow_b)
    );

    nms_iou_unit #(.N(16), .FRAC(10)) u_iou_ref (
        .a_x(t_ax), .a_y(t_ay), .a_w(t_aw), .a_h(t_ah),
        .b_x(t_bx), .b_y(t_by), .b_w(t_bw), .b_h(t_bh),
        .iou(t_iou)
    );

    always @(posedge clk) begin
        if (out_valid_a && out_ready) begin
            hs_a <= hs_a + 1;
            lx_a <= out_x_a;
            lw_a <= out_w_a;
        end
        if (out_valid_b && out_ready) hs_b <= hs_b + 1;
        if (frame_done_a) fd_a <= fd_a + 1;
        if (frame_done_b) begin
            fd_b    <= fd_b + 1;
            ov_fd_b <= overflow_b;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input bit sel, input logic [15:0] x, y, w, h, input bit last);
        bit done;
        done = 1'b0;
        @(negedge clk);
        in_x = x; in_y = y; in_w = w; in_h = h; in_last = last;
        if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if ((sel ? in_ready_b : in_ready_a) === 1'b1) begin
                @(posedge clk);
                #1;
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        check("accept", done, 1'b1);
    endtask

    task automatic wait_idle(input bit sel);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if ((sel ? in_ready_b : in_ready_a) === 1'b1) begin
                done = 1'b1;
                break;
            end
        end
        check("idle_timeout", done, 1'b1);
    endtask

    task automatic iou_case(input string tag, input logic [15:0] ax, ay, aw, ah,
                            input logic [15:0] bx, by, bw, bh, input logic [15:0] exp);
        t_ax = ax; t_ay = ay; t_aw = aw; t_ah = ah;
        t_bx = bx; t_by = by; t_bw = bw; t_bh = bh;
        #1;
        check(tag, t_iou, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0, fd0;

        iou_case("iou_same",    0, 0, 10, 10,  0, 0, 10, 10, 16'd1024);
        iou_case("iou_shift5",  0, 0, 10, 10,  5, 0, 10, 10, 16'd341);
        iou_case("iou_zero",    0, 0, 0, 0,    0, 0, 0, 0,   16'd0);
        iou_case("iou_touch",   0, 0, 10, 10,  10, 0, 10, 10, 16'd0);
        iou_case("iou_disjoint",0, 0, 4, 4,    10, 10, 4, 4, 16'd0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready",  in_ready_a, 1'b1);
        check("rst_out_valid", out_valid_a, 1'b0);
        check("rst_frame_done",frame_done_a, 1'b0);
        check("rst_kept",      kept_count_a, 0);
        check("rst_overflow",  overflow_a, 1'b0);
        check("rst_out_box",   {out_x_a, out_y_a, out_w_a, out_h_a}, 64'd0);
        check("rst_kept_b",    kept_count_b, 0);

        // Identical box suppressed at IoU 1.0
        iou_thresh = 16'd512;
        hs0 = hs_a; fd0 = fd_a;
        push(0, 0, 0, 10, 10, 0);
        wait_idle(0);
        check("dup_first_emit", hs_a - hs0, 1);
        check("dup_first_box",  {lx_a, lw_a}, {16'd0, 16'd10});
        check("dup_kept1",      kept_count_a, 1);
        push(0, 0, 0, 10, 10, 1);
        wait_idle(0);
        check("dup_second_supp", hs_a - hs0, 1);
        check("dup_frame_done",  fd_a - fd0, 1);
        check("dup_kept_clear",  kept_count_a, 0);

        // IoU 341 passes 512, fails 300
        hs0 = hs_a; fd0 = fd_a;
        push(0, 0, 0, 10, 10, 0);
        wait_idle(0);
        push(0, 5, 0, 10, 10, 1);
        wait_idle(0);
        check("shift_both_emit", hs_a - hs0, 2);
        check("shift_last_box",  lx_a, 16'd5);
        check("shift_fd",        fd_a - fd0, 1);
        iou_thresh = 16'd300;
        hs0 = hs_a;
        push(0, 0, 0, 10, 10, 0);
        wait_idle(0);
        push(0, 5, 0, 10, 10, 1);
        wait_idle(0);
        check("shift_thr300", hs_a - hs0, 1);
        iou_thresh = 16'd512;

        // Backpressure in EMIT
        hs0 = hs_a; fd0 = fd_a;
        @(negedge clk);
        out_ready = 1'b0;
        push(0, 3, 7, 9, 11, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid_ready", {out_valid_a, in_ready_a}, 2'b10);
            check("bp_box", {out_x_a, out_y_a, out_w_a, out_h_a},
                  {16'd3, 16'd7, 16'd9, 16'd11});
        end
        check("bp_no_hs", hs_a - hs0, 0);
        out_ready = 1'b1;
        wait_idle(0);
        check("bp_single_hs", hs_a - hs0, 1);
        check("bp_fd", fd_a - fd0, 1);

        // Zero-size boxes: union 0, both kept
        hs0 = hs_a;
        push(0, 0, 0, 0, 0, 0);
        wait_idle(0);
        check("zero_kept1", kept_count_a, 1);
        push(0, 0, 0, 0, 0, 1);
        wait_idle(0);
        check("zero_both", hs_a - hs0, 2);

        // DEPTH=2 overflow
        push(1, 0, 0, 4, 4, 0);
        wait_idle(1);
        push(1, 10, 10, 4, 4, 0);
        wait_idle(1);
        check("ovf_kept2", kept_count_b, 2);
        check("ovf_not_yet", overflow_b, 1'b0);
        push(1, 20, 20, 4, 4, 1);
        wait_idle(1);
        check("ovf_emitted", hs_b, 2);
        check("ovf_fd", fd_b, 1);
        check("ovf_at_fd", ov_fd_b, 1'b1);
        check("ovf_cleared", overflow_b, 1'b0);
        check("ovf_kept_clear", kept_count_b, 0);

        // Reset in the middle of COMPARE
        push(0, 0, 0, 4, 4, 0);
        wait_idle(0);
        push(0, 10, 10, 4, 4, 0);
        wait_idle(0);
        push(0, 20, 20, 4, 4, 0);
        wait_idle(0);
        check("mid_kept3", kept_count_a, 3);
        hs0 = hs_a; fd0 = fd_a;
        push(0, 30, 30, 4, 4, 0);
        check("mid_in_compare", {in_ready_a, out_valid_a}, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", in_ready_a, 1'b1);
        check("mid_rst_kept",  kept_count_a, 0);
        check("mid_rst_valid", out_valid_a, 1'b0);
        check("mid_rst_no_hs", hs_a - hs0, 0);
        push(0, 0, 0, 10, 10, 1);
        wait_idle(0);
        check("mid_next_emit", hs_a - hs0, 1);
        check("mid_next_fd",   fd_a - fd0, 1);
        check("mid_next_kept", kept_count_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
